pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the multi-issue datapath, the generalised successor to the fixed two-lane ID/EX latch. It carries LANES instruction slots, each with:
- a control word
- a data payload
- per-lane exception flags

A shared PC travels with the bundle. The block adds a valid/ready handshake with a 2-entry skid buffer, flush, per-lane kill of lanes younger than an excepting lane, and a saturating stall counter. It sits between any two pipeline stages (ID/EX first, then EX/MEM).

---
 rtl/pipe_stage_reg_if.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake/bundle bus for pipe_stage_reg.
// Ports (slave = pipeline register side):
//   flush, in_valid/in_ready, in_lane_valid/in_ctrl/in_data/in_epc_write/
//   in_cause_write/in_pc        producer -> register
//   out_valid/out_ready, out_lane_valid/out_ctrl/out_data/out_epc_write/
//   out_cause_write/out_pc      register -> consumer
//   stall_cnt                   saturating count of stalled output cycles
interface pipe_stage_reg_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES-1:0]          in_lane_valid;
  logic [LANES*CTRL_W-1:0]   in_ctrl;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES-1:0]          in_epc_write;
  logic [LANES-1:0]          in_cause_write;
  logic [PC_W-1:0]           in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0]          out_lane_valid;
  logic [LANES*CTRL_W-1:0]   out_ctrl;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          out_epc_write;
  logic [LANES-1:0]          out_cause_write;
  logic [PC_W-1:0]           out_pc;
  logic [CNT_W-1:0]          stall_cnt;

  modport slave (
    input  flush, in_valid, in_lane_valid, in_ctrl, in_data, in_epc_write,
           in_cause_write, in_pc, out_ready,
    output in_ready, out_valid, out_lane_valid, out_ctrl, out_data,
           out_epc_write, out_cause_write, out_pc, stall_cnt
  );

  modport master (
    output flush, in_valid, in_lane_valid, in_ctrl, in_data, in_epc_write,
           in_cause_write, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_ctrl, out_data,
           out_epc_write, out_cause_write, out_pc, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Multi-lane inter-stage pipeline register with a 2-entry skid buffer
// (MAIN drives the outputs, SKID holds the younger bundle under
// backpressure), flush, kill of lanes younger than the oldest excepting
// lane, and a saturating stall counter.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    pipe_stage_reg_if.slave (handshake, bundle fields, stall_cnt)
module pipe_stage_reg #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  localparam int unsigned CW = LANES * CTRL_W;
  localparam int unsigned DW = LANES * DATA_W;

  // state[0] = main_valid, state[1] = skid_valid
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_in_ready;
  logic              w_in_ready_nxt;
  logic              w_accept;
  logic              w_fire;
  logic              w_ld_main_in;
  logic              w_ld_skid_in;
  logic              w_ld_main_skid;

  logic [LANES-1:0]  r_main_lv, r_main_epc, r_main_cause;
  logic [CW-1:0]     r_main_ctrl;
  logic [DW-1:0]     r_main_data;
  logic [PC_W-1:0]   r_main_pc;
  logic [LANES-1:0]  r_skid_lv, r_skid_epc, r_skid_cause;
  logic [CW-1:0]     r_skid_ctrl;
  logic [DW-1:0]     r_skid_data;
  logic [PC_W-1:0]   r_skid_pc;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [LANES-1:0]  w_cap_lv, w_cap_epc, w_cap_cause;
  logic [CW-1:0]     w_cap_ctrl;
  logic              w_seen_exc;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_fire   = r_state[0] && bus.out_ready;

  // Capture view of the incoming bundle: lanes after the oldest valid
  // excepting lane, and empty lanes, lose valid/ctrl/exception bits.
  always_comb begin : lane_kill
    w_cap_lv    = '0;
    w_cap_ctrl  = '0;
    w_cap_epc   = '0;
    w_cap_cause = '0;
    w_seen_exc  = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (bus.in_lane_valid[i] && !w_seen_exc) begin
        w_cap_lv[i]                    = 1'b1;
        w_cap_ctrl[i*CTRL_W +: CTRL_W] = bus.in_ctrl[i*CTRL_W +: CTRL_W];
        w_cap_epc[i]                   = bus.in_epc_write[i];
        w_cap_cause[i]                 = bus.in_cause_write[i];
        if (bus.in_epc_write[i] || bus.in_cause_write[i]) w_seen_exc = 1'b1;
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  // Next state and load selects; flush overrides everything.
  always_comb begin : next_state
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_ld_skid_in = 1'b1;
            w_state_nxt  = ST_FULL;
          end else if (w_fire) begin
            w_state_nxt  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_fire) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
    w_in_ready_nxt = !w_state_nxt[1];
  end

  // Bundle storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_lv    <= '0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_main_epc   <= '0;
      r_main_cause <= '0;
      r_main_pc    <= '0;
      r_skid_lv    <= '0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_epc   <= '0;
      r_skid_cause <= '0;
      r_skid_pc    <= '0;
    end else if (bus.flush) begin
      r_main_lv    <= '0;
      r_main_ctrl  <= '0;
      r_main_epc   <= '0;
      r_main_cause <= '0;
      r_skid_lv    <= '0;
      r_skid_ctrl  <= '0;
      r_skid_epc   <= '0;
      r_skid_cause <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_lv    <= w_cap_lv;
        r_main_ctrl  <= w_cap_ctrl;
        r_main_data  <= bus.in_data;
        r_main_epc   <= w_cap_epc;
        r_main_cause <= w_cap_cause;
        r_main_pc    <= bus.in_pc;
      end else if (w_ld_main_skid) begin
        r_main_lv    <= r_skid_lv;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
        r_main_epc   <= r_skid_epc;
        r_main_cause <= r_skid_cause;
        r_main_pc    <= r_skid_pc;
      end
      if (w_ld_skid_in) begin
        r_skid_lv    <= w_cap_lv;
        r_skid_ctrl  <= w_cap_ctrl;
        r_skid_data  <= bus.in_data;
        r_skid_epc   <= w_cap_epc;
        r_skid_cause <= w_cap_cause;
        r_skid_pc    <= bus.in_pc;
      end
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_state[0] && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.out_valid       = r_state[0];
  assign bus.out_lane_valid  = r_main_lv;
  assign bus.out_ctrl        = r_main_ctrl;
  assign bus.out_data        = r_main_data;
  assign bus.out_epc_write   = r_main_epc;
  assign bus.out_cause_write = r_main_cause;
  assign bus.out_pc          = r_main_pc;
  assign bus.stall_cnt       = r_stall_cnt;

endmodule
